netlist_eval_sched: RTL and testbench
=====================================

Name: netlist_eval_sched

Overview:
- Time-shares one instance of a contest combinational netlist (14 inputs, 8 outputs, gate-mapped, no clock) among several requesters.
- Each request is a 14-bit input vector. The block arbitrates round-robin, registers the winning vector onto the netlist inputs and waits a fixed settle time. It then captures the 8-bit outputs and returns them tagged with the requester ID.
- Sits between the pattern generators / equivalence checkers and the netlist under evaluation.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- IN_W, 14: netlist input vector width.
- OUT_W, 8: netlist output vector width.
- SETTLE, 2: cycles the netlist inputs are held stable before capture; must be ≥1 (elaboration-time check, fatal if 0).
- ID_W, $clog2(NUM_REQ): requester ID width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_vec  in  NUM_REQ*IN_W  packed vectors; requester i occupies bits [i*IN_W +: IN_W].
- dp_in  out  IN_W  registered drive to the netlist inputs.
- dp_out  in  OUT_W  netlist outputs (combinational from dp_in).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  OUT_W  captured netlist outputs.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert handled externally) forces the following, including mid-operation; any in-flight request is dropped and not replayed:
  - state=IDLE, rr pointer=0, dp_in=0, settle counter=0;
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0.
- FSM states and transitions:
  - IDLE: if any req_valid, the arbiter grants one requester. req_ready[g] is combinationally high in this cycle only. At the clock edge (accept edge T): dp_in<=req_vec[g], grant id latched, counter<=SETTLE-1, go to SETTLE.
  - SETTLE: dp_in held constant. While the counter is nonzero it decrements. On the edge with counter==0: rsp_data<=dp_out, rsp_id<=latched id, rsp_valid<=1, go to RESP.
  - RESP: outputs held stable until the edge where rsp_valid&&rsp_ready. Then rsp_valid<=0 and the state returns to IDLE.
- Latency: dp_out is sampled at edge T+SETTLE; rsp_valid is first high in the cycle after that edge.
- Minimum request-to-request spacing is SETTLE+2 cycles with rsp_ready tied high. There is no accept/response overlap.
- req_ready is never asserted outside IDLE. req_valid in other states is ignored and stays pending; requesters must hold valid and vector until accepted.
- Round-robin arbitration:
  - Search starts at the rr pointer and wraps modulo NUM_REQ.
  - On accept, pointer <= g+1, with wrap from NUM_REQ-1 to 0.
  - A requester that drops valid before being granted loses nothing.
- dp_in keeps the last vector after completion (no return to 0), so the netlist does not toggle when idle.
- rsp_data and rsp_id are stable whenever rsp_valid=1 and rsp_ready=0.
- A rsp_ready high in the same cycle rsp_valid first rises completes the response at the next edge.

Decomposition:
- Shared package netlist_eval_pkg:
  - state enum {IDLE, SETTLE, RESP};
  - default widths IN_W=14, OUT_W=8.
- Sub-module rr_arb (NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, binary index, any_grant;
  - purely combinational.
- Pointer and FSM live in netlist_eval_sched.

Test Plan:
- Reset mid-SETTLE:
  - Stimulus: req_valid=0001, vec=14'h2A5B; assert rst_n=0 one cycle after accept.
  - Required: dp_in=0, busy=0, rsp_valid never rises; pointer restarts at 0.
- Single request, SETTLE=2, rsp_ready=1:
  - Stimulus: req 2 with vec=14'h1234 at T.
  - Required: req_ready=0100 at T. dp_in=14'h1234 after T. rsp_valid high cycle T+3 with rsp_id=2 and rsp_data equal to the golden model of the netlist for 14'h1234; busy low at T+4.
- All four valid continuously:
  - Required: grants in order 0,1,2,3,0, spaced exactly 4 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_data/rsp_id unchanged and req_ready=0 throughout; the next grant occurs in the cycle after the rsp handshake.
- Pointer wrap:
  - Stimulus: only req 3 then req 0 and req 3 both valid.
  - Required: after granting 3 the pointer is 0, so 0 is granted before 3.
- SETTLE=1 regression:
  - Stimulus: 1000 random vectors from random requesters.
  - Required: every rsp_data matches the golden model and rsp_id matches the source; no lost or duplicated responses.

Source files
------------

// File: rtl/netlist_eval_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : netlist_eval_pkg                                              |
// | Purpose  : Shared types and default widths for the netlist evaluation    |
// |            scheduler (FSM state encoding, netlist I/O widths).           |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package netlist_eval_pkg;

  localparam int DEF_IN_W  = 14;
  localparam int DEF_OUT_W = 8;

  // The ST_ prefix keeps the state literals from colliding with the SETTLE
  // parameter of the scheduler, which would otherwise shadow the literal.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage : netlist_eval_pkg
`default_nettype wire

// File: rtl/netlist_eval_sched_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb                                                        |
// | Purpose  : Combinational round-robin arbiter. The search starts at the   |
// |            pointer and wraps modulo NUM_REQ; the first active request    |
// |            found wins.                                                   |
// | Ports    : req_i        request vector                                   |
// |            ptr_i        search start index                               |
// |            en_i         arbitration enable (grant forced to zero if low) |
// |            grant_o      one-hot grant                                    |
// |            idx_o        binary index of the grant                        |
// |            any_grant_o  high when a grant is issued                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_grant_o
);

  always_comb begin
    int          j;
    logic [ID_W-1:0] j_idx;
    grant_o     = '0;
    idx_o       = '0;
    any_grant_o = 1'b0;
    j           = 0;
    j_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j     = (int'(ptr_i) + i) % NUM_REQ;
      j_idx = ID_W'(j);
      if (en_i && !any_grant_o && req_i[j_idx]) begin
        grant_o[j_idx] = 1'b1;
        idx_o          = j_idx;
        any_grant_o    = 1'b1;
      end
    end
  end

endmodule : rr_arb
`default_nettype wire

// File: rtl/netlist_eval_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : netlist_eval_sched                                            |
// | Purpose  : Time-shares one combinational netlist among NUM_REQ           |
// |            requesters. Arbitrates round-robin, drives the winning vector |
// |            onto the netlist, waits SETTLE cycles, captures the outputs   |
// |            and returns them tagged with the requester ID.                |
// | Ports    : clk, rst_n     clock, async active-low reset                  |
// |            req_valid_i    per-requester valid                            |
// |            req_ready_o    per-requester accept (one-hot or zero)         |
// |            req_vec_i      packed request vectors, i at [i*IN_W +: IN_W]  |
// |            dp_in_o        registered netlist input drive                 |
// |            dp_out_i       netlist outputs                                |
// |            rsp_valid_o / rsp_ready_i   response handshake                |
// |            rsp_id_o / rsp_data_o       response tag and captured data    |
// |            busy_o         high whenever not idle                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module netlist_eval_sched
  import netlist_eval_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SETTLE  = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*IN_W-1:0] req_vec_i,
  output logic [IN_W-1:0]         dp_in_o,
  input  logic [OUT_W-1:0]        dp_out_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [OUT_W-1:0]        rsp_data_o,
  output logic                    busy_o
);

  if (SETTLE < 1) begin : g_settle_check
    $fatal(1, "netlist_eval_sched: SETTLE must be >= 1");
  end

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_check
    $fatal(1, "netlist_eval_sched: NUM_REQ must be in 2..16");
  end

  // Counter only needs to hold SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [IN_W-1:0]   dp_in_q, dp_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;

  logic              arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_grant;
  logic [ID_W-1:0]   ptr_next;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the state register already reads IDLE.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .en_i        (arb_en),
    .grant_o     (grant),
    .idx_o       (grant_idx),
    .any_grant_o (any_grant)
  );

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dp_in_d     = dp_in_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_grant) begin
          dp_in_d = req_vec_i[int'(grant_idx)*IN_W +: IN_W];
          id_d    = grant_idx;
          cnt_d   = CNT_LOAD;
          ptr_d   = ptr_next;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d  = dp_out_i;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dp_in_q     <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dp_in_q     <= dp_in_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = grant;
  assign dp_in_o     = dp_in_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule : netlist_eval_sched
`default_nettype wire

// File: tb/tb_netlist_eval_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_netlist_eval_sched                                         |
// | Purpose  : Self-checking bench. Instance u_dut2 (SETTLE=2) takes the     |
// |            directed steps; u_dut1 (SETTLE=1) takes a randomized stream   |
// |            scored against a queue-based reference model.                 |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_netlist_eval_sched;

  localparam int N   = 4;
  localparam int IW  = 14;
  localparam int OW  = 8;
  localparam int IDW = 2;
  localparam int NUM_RAND = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Stand-in for the contest netlist: an arbitrary gate-level style mapping.
  function automatic logic [OW-1:0] nl(input logic [IW-1:0] v);
    logic [7:0] a, b;
    a = v[7:0];
    b = {2'b00, v[13:8]};
    return (a & ~b) ^ {b[5:0], a[7:6]} ^ 8'h5A;
  endfunction

  // SETTLE=2 instance
  logic [N-1:0]    v2, rdy2;
  logic [N*IW-1:0] vec2;
  logic [IW-1:0]   dpi2;
  logic [OW-1:0]   dpo2, rd2;
  logic            rv2, rr2, busy2;
  logic [IDW-1:0]  rid2;
  assign dpo2 = nl(dpi2);

  netlist_eval_sched #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .SETTLE(2), .ID_W(IDW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v2), .req_ready_o(rdy2), .req_vec_i(vec2),
    .dp_in_o(dpi2), .dp_out_i(dpo2), .rsp_valid_o(rv2), .rsp_ready_i(rr2),
    .rsp_id_o(rid2), .rsp_data_o(rd2), .busy_o(busy2));

  // SETTLE=1 instance
  logic [N-1:0]    v1, rdy1;
  logic [N*IW-1:0] vec1;
  logic [IW-1:0]   dpi1;
  logic [OW-1:0]   dpo1, rd1;
  logic            rv1, rr1, busy1;
  logic [IDW-1:0]  rid1;
  assign dpo1 = nl(dpi1);

  netlist_eval_sched #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .SETTLE(1), .ID_W(IDW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v1), .req_ready_o(rdy1), .req_vec_i(vec1),
    .dp_in_o(dpi1), .dp_out_i(dpo1), .rsp_valid_o(rv1), .rsp_ready_i(rr1),
    .rsp_id_o(rid1), .rsp_data_o(rd1), .busy_o(busy1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to 2 ns after the next rising edge; inputs are driven and outputs
  // sampled there.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant2(input string tag);
    int n;
    n = 0;
    while (rdy2 == '0 && n < 20) begin
      step();
      #1;
      n++;
    end
    check(tag, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_idle2();
    int n;
    n = 0;
    while (busy2 && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy2), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state for the randomized stream
  logic [N-1:0]  pend;
  logic [IW-1:0] pend_vec [N];
  int            q_id[$];
  logic [IW-1:0] q_vec[$];
  int            mptr, gen, accepted, responses;

  initial begin
    logic [IW-1:0] cvec [N];
    int prev;
    int g, j;
    int eid;
    logic [IW-1:0] evec;
    logic [OW-1:0] hold_d;
    logic [IDW-1:0] hold_id;

    rst_n = 1'b0;
    v2 = '0; vec2 = '0; rr2 = 1'b1;
    v1 = '0; vec1 = '0; rr1 = 1'b0;
    pend = '0;
    for (int i = 0; i < N; i++) pend_vec[i] = '0;
    mptr = 0; gen = 0; accepted = 0; responses = 0;

    // Reset state, with all requests asserted to show req_ready stays low.
    v2 = 4'b1111;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dp_in",  32'(dpi2),  32'd0);
    check("rst_busy",   32'(busy2), 32'd0);
    check("rst_rsp_v",  32'(rv2),   32'd0);
    check("rst_rsp_id", 32'(rid2),  32'd0);
    check("rst_rsp_d",  32'(rd2),   32'd0);
    check("rst_ready",  32'(rdy2),  32'd0);
    v2 = '0;
    rst_n = 1'b1;
    step();

    // Single request from requester 2
    vec2[2*IW +: IW] = 14'h1234;
    v2 = 4'b0100;
    #1;
    check("single_ready_T", 32'(rdy2), 32'b0100);
    step();
    v2 = '0;
    #1;
    check("single_dp_in",  32'(dpi2),  32'h1234);
    check("single_busy",   32'(busy2), 32'd1);
    check("single_rv_T1",  32'(rv2),   32'd0);
    step();
    check("single_rv_T2",  32'(rv2),   32'd0);
    step();
    check("single_rv_T3",  32'(rv2),   32'd1);
    check("single_id",     32'(rid2),  32'd2);
    check("single_data",   32'(rd2),   32'(nl(14'h1234)));
    step();
    check("single_busy_T4", 32'(busy2), 32'd0);
    check("single_rv_T4",   32'(rv2),   32'd0);
    check("single_dp_hold", 32'(dpi2),  32'h1234);

    // Reset one cycle after accept (requester 0); pointer is 3 beforehand.
    vec2[0 +: IW] = 14'h2A5B;
    v2 = 4'b0001;
    #1;
    check("rstmid_ready", 32'(rdy2), 32'b0001);
    step();
    v2 = '0;
    rst_n = 1'b0;
    #1;
    check("rstmid_dp_in", 32'(dpi2),  32'd0);
    check("rstmid_busy",  32'(busy2), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rstmid_rv_hold", 32'(rv2), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rstmid_rv_after", 32'(rv2),   32'd0);
      check("rstmid_idle",     32'(busy2), 32'd0);
    end

    // All four valid: pointer must have restarted at 0.
    for (int i = 0; i < N; i++) begin
      cvec[i] = IW'($urandom);
      vec2[i*IW +: IW] = cvec[i];
    end
    v2 = 4'b1111;
    #1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant2("cont_timeout");
      check("cont_grant", 32'(rdy2), 32'(1 << (k % N)));
      if (k > 0) check("cont_spacing", 32'(cyc - prev), 32'd4);
      prev = cyc;
      step();
      if (k == 4) v2 = '0;
      #1;
      check("cont_dp_in", 32'(dpi2), 32'(cvec[k % N]));
    end
    wait_idle2();

    // Backpressure: grant 1, hold response 10 cycles while 3 is pending.
    rr2 = 1'b0;
    vec2[1*IW +: IW] = 14'h3C3C;
    vec2[3*IW +: IW] = 14'h0F0F;
    v2 = 4'b0010;
    #1;
    wait_grant2("bp_grant_timeout");
    check("bp_grant", 32'(rdy2), 32'b0010);
    step();
    v2 = 4'b1000;
    begin
      int n;
      n = 0;
      while (!rv2 && n < 10) begin
        step();
        n++;
      end
    end
    check("bp_rv", 32'(rv2), 32'd1);
    hold_d  = rd2;
    hold_id = rid2;
    check("bp_data", 32'(hold_d),  32'(nl(14'h3C3C)));
    check("bp_id",   32'(hold_id), 32'd1);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_rv_hold",   32'(rv2),  32'd1);
      check("bp_data_hold", 32'(rd2),  32'(nl(14'h3C3C)));
      check("bp_id_hold",   32'(rid2), 32'd1);
      check("bp_ready_low", 32'(rdy2), 32'd0);
      step();
    end
    rr2 = 1'b1;
    #1;
    check("bp_ready_resp", 32'(rdy2), 32'd0);
    step();
    #1;
    check("bp_next_grant", 32'(rdy2), 32'b1000);
    step();
    v2 = '0;
    #1;
    check("bp_next_dp_in", 32'(dpi2), 32'h0F0F);
    wait_idle2();

    // Pointer wrap: grant 3 alone, then 0 and 3 both valid -> 0 first.
    vec2[3*IW +: IW] = 14'h1111;
    v2 = 4'b1000;
    #1;
    wait_grant2("wrap_t0");
    check("wrap_grant3", 32'(rdy2), 32'b1000);
    step();
    vec2[0 +: IW] = 14'h2222;
    v2 = 4'b1001;
    #1;
    wait_grant2("wrap_t1");
    check("wrap_grant0", 32'(rdy2), 32'b0001);
    step();
    v2 = 4'b1000;
    #1;
    wait_grant2("wrap_t2");
    check("wrap_grant3b", 32'(rdy2), 32'b1000);
    step();
    v2 = '0;
    wait_idle2();

    // Randomized stream against SETTLE=1 instance
    for (int c = 0; c < 20000 && responses < NUM_RAND; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && gen < NUM_RAND && $urandom_range(0, 2) == 0) begin
          pend[i]     = 1'b1;
          pend_vec[i] = IW'($urandom);
          gen++;
        end
        vec1[i*IW +: IW] = pend_vec[i];
      end
      v1  = pend;
      rr1 = ($urandom_range(0, 3) != 0);
      #1;
      if (rdy1 != '0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (g < 0 && pend[j]) g = j;
        end
        check("rand_grant", 32'(rdy1), (g < 0) ? 32'd0 : 32'(1 << g));
        if (g >= 0) begin
          q_id.push_back(g);
          q_vec.push_back(pend_vec[g]);
          pend[g] = 1'b0;
          mptr = (g + 1) % N;
          accepted++;
          check("rand_inflight", 32'(q_id.size() <= 1), 32'd1);
        end
      end
      if (rv1) check("rand_ready_in_resp", 32'(rdy1), 32'd0);
      if (rv1 && rr1) begin
        if (q_id.size() == 0) begin
          check("rand_unexpected_rsp", 32'(rid1), 32'hFFFF_FFFF);
        end else begin
          eid  = q_id.pop_front();
          evec = q_vec.pop_front();
          check("rand_id",   32'(rid1), 32'(eid));
          check("rand_data", 32'(rd1),  32'(nl(evec)));
        end
        responses++;
      end
      step();
    end
    v1 = '0;
    check("rand_responses", 32'(responses), 32'(NUM_RAND));
    check("rand_accepted",  32'(accepted),  32'(NUM_RAND));
    check("rand_queue_empty", 32'(q_id.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_netlist_eval_sched
`default_nettype wire
